// File: rtl/mac_fp_pkg.sv
// mac_fp_pkg
//   Shared types for the FP MAC writeback stage: operation mode encoding,
//   the {NV,OF,UF,NX} exception flag struct, a result entry struct sized by
//   the default tag width, and the per-mode result formatter.
//   No ports.
package mac_fp_pkg;

   localparam int DATA_W    = 128;
   localparam int TAG_W_DEF = 4;

   typedef enum logic [1:0] {
      MODE_FP16 = 2'b00,
      MODE_MIX  = 2'b01,
      MODE_FP32 = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef struct packed {
      logic nv;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [TAG_W_DEF-1:0] tag;
      fflags_t              flags;
   } res_entry_t;

   // Zero-extends the meaningful low part of the raw MAC output.
   // The reserved mode yields zero data.
   function automatic logic [DATA_W-1:0] fmt_data(input logic [DATA_W-1:0] raw,
                                                 input mode_e             mode);
      case (mode)
         MODE_FP16:           fmt_data = {112'b0, raw[15:0]};
         MODE_MIX, MODE_FP32: fmt_data = {96'b0, raw[31:0]};
         default:             fmt_data = '0;
      endcase
   endfunction

endpackage

// File: rtl/mac_res_fifo.sv
// mac_res_fifo
//   Generic synchronous first-word-fall-through FIFO. The head entry is read
//   straight from the storage registers; it reads as zero while empty.
//   Push and pop in the same cycle are legal at any occupancy.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          remove head entry (ignored while empty)
//   head         current head entry
//   full/empty   occupancy status
//   count        number of stored entries
module mac_res_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0],
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop = pop && !empty;
   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign head   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= next_ptr(wr_ptr);
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // When full, wr_ptr == rd_ptr; a simultaneous pop has already presented
   // the old head combinationally, so overwriting that slot is safe.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop));

endmodule

// File: rtl/mac_fp_result_stage.sv
// mac_fp_result_stage
//   Writeback stage behind the fixed-latency FP MAC. Tracks issued ops,
//   captures the MAC result/flags when an op reaches the end of the track
//   pipe, formats it per mode and queues it in a FWFT FIFO. Issue credits
//   cover in-flight ops plus queued results so nothing is ever dropped.
//   Keeps sticky, software-clearable accrued flags.
// Configuration macro: MAC_RES_PERF_CNT_EN adds perf_retired/perf_stall.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        issue handshake; in_mode/in_tag describe the op
//   mac_result, mac_nv..nx   raw MAC outputs, valid MAC_LAT cycles after issue
//   out_valid/out_ready      result handshake; out_data/out_tag/out_flags
//   fflags_clr, fflags       sticky {NV,OF,UF,NX} clear and value
//   perf_retired, perf_stall (optional) push count, stalled-issue cycles
module mac_fp_result_stage
   import mac_fp_pkg::*;
#(
   parameter int MAC_LAT = 2,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [127:0]     mac_result,
   input  logic             mac_nv,
   input  logic             mac_of,
   input  logic             mac_uf,
   input  logic             mac_nx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_flags,
   input  logic             fflags_clr,
   output logic [3:0]       fflags
`ifdef MAC_RES_PERF_CNT_EN
   ,
   output logic [31:0]      perf_retired,
   output logic [31:0]      perf_stall
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TAIL  = MAC_LAT - 1;

   typedef struct packed {
      logic [127:0]     data;
      logic [TAG_W-1:0] tag;
      fflags_t          flags;
   } entry_t;

   logic [MAC_LAT-1:0] pipe_valid;
   mode_e              pipe_mode [MAC_LAT];
   logic [TAG_W-1:0]   pipe_tag  [MAC_LAT];

   logic             issue;
   logic             pop;
   logic             retire;
   entry_t           retire_entry;
   entry_t           head_entry;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       sticky;

   assign issue  = in_valid && in_ready;
   assign pop    = out_valid && out_ready;
   assign retire = pipe_valid[TAIL];

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= issue;
         for (int i = 1; i < MAC_LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_mode[0] <= mode_e'(in_mode);
      pipe_tag[0]  <= in_tag;
      for (int i = 1; i < MAC_LAT; i++) begin
         pipe_mode[i] <= pipe_mode[i-1];
         pipe_tag[i]  <= pipe_tag[i-1];
      end
   end

   // Reserved mode discards the MAC flags and reports invalid-operation.
   always_comb begin
      retire_entry      = '0;
      retire_entry.data = fmt_data(mac_result, pipe_mode[TAIL]);
      retire_entry.tag  = pipe_tag[TAIL];
      if (pipe_mode[TAIL] == MODE_RSVD) retire_entry.flags = fflags_t'(4'b1000);
      else retire_entry.flags = fflags_t'({mac_nv, mac_of, mac_uf, mac_nx});
   end

   mac_res_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (retire),
      .push_data (retire_entry),
      .pop       (out_ready),
      .head      (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = head_entry.data;
   assign out_tag   = head_entry.tag;
   assign out_flags = head_entry.flags;

   // Credits count in-flight ops plus queued results.
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt + CNT_W'(issue) - CNT_W'(pop);
   end
   assign in_ready = (cnt < CNT_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) sticky <= '0;
      else     sticky <= (fflags_clr ? 4'b0 : sticky) | (retire ? retire_entry.flags : 4'b0);
   end
   assign fflags = sticky;

   a_credit_cover: assert property (@(posedge clk) disable iff (rst)
      (fifo_count <= cnt) && !(fifo_full && retire && !pop));

`ifdef MAC_RES_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         perf_retired <= (fflags_clr ? 32'd0 : perf_retired) + 32'(retire);
         perf_stall   <= (fflags_clr ? 32'd0 : perf_stall) + 32'(in_valid && !in_ready);
      end
   end
`endif

endmodule

// File: tb/tb_mac_fp_result_stage.sv
module tb_mac_fp_result_stage;

   localparam int MAC_LAT = 2;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic [127:0]     mac_result;
   logic             mac_nv, mac_of, mac_uf, mac_nx;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic [TAG_W-1:0] out_tag;
   logic [3:0]       out_flags;
   logic             fflags_clr;
   logic [3:0]       fflags;
`ifdef MAC_RES_PERF_CNT_EN
   logic [31:0]      perf_retired;
   logic [31:0]      perf_stall;
`endif

   always #5 clk = ~clk;

   mac_fp_result_stage #(.MAC_LAT(MAC_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mode    (in_mode),
      .in_tag     (in_tag),
      .mac_result (mac_result),
      .mac_nv     (mac_nv),
      .mac_of     (mac_of),
      .mac_uf     (mac_uf),
      .mac_nx     (mac_nx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_flags  (out_flags),
      .fflags_clr (fflags_clr),
      .fflags     (fflags)
`ifdef MAC_RES_PERF_CNT_EN
      ,
      .perf_retired (perf_retired),
      .perf_stall   (perf_stall)
`endif
   );

   typedef struct {
      int               due;
      logic [127:0]     raw;
      logic [3:0]       flg;
      logic [1:0]       mode;
      logic [TAG_W-1:0] tag;
   } op_t;

   typedef struct {
      logic [127:0]     data;
      logic [TAG_W-1:0] tag;
      logic [3:0]       flags;
   } ent_t;

   op_t         pend[$];
   ent_t        exp_q[$];
   logic [3:0]  ff_m;
   int          cyc;
   int          n_tests;
   int          n_fail;
   int unsigned retired_m;
   int unsigned stall_m;

   function automatic ent_t fmt(input op_t o);
      ent_t e;
      e.tag = o.tag;
      case (o.mode)
         2'b00:   begin e.data = 128'(o.raw[15:0]); e.flags = o.flg;   end
         2'b01,
         2'b10:   begin e.data = 128'(o.raw[31:0]); e.flags = o.flg;   end
         default: begin e.data = '0;                e.flags = 4'b1000; end
      endcase
      return e;
   endfunction

   task automatic rnd_mac();
      mac_result = {$urandom, $urandom, $urandom, $urandom};
      {mac_nv, mac_of, mac_uf, mac_nx} = 4'($urandom);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'($urandom);
      fflags_clr = 1'b0;
      rnd_mac();
      @(posedge clk); #1;
      cyc++;
      rst = 1'b0;
      pend.delete();
      exp_q.delete();
      ff_m      = '0;
      retired_m = 0;
      stall_m   = 0;
   endtask

   // Drives one cycle of stimulus and advances the model by one clock.
   task automatic step(input logic iv, input logic [1:0] md, input logic [TAG_W-1:0] tg,
                       input logic [127:0] raw, input logic [3:0] flg,
                       input logic ordy, input logic clr);
      op_t  o_ret;
      op_t  o_new;
      ent_t e;
      logic acc;
      acc = iv && ((pend.size() + exp_q.size()) < DEPTH);
      in_valid   = iv;
      in_mode    = md;
      in_tag     = tg;
      out_ready  = ordy;
      fflags_clr = clr;
      rnd_mac();
      if (clr) begin
         ff_m      = '0;
         retired_m = 0;
         stall_m   = 0;
      end
      if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
         o_ret = pend.pop_front();
         mac_result = o_ret.raw;
         {mac_nv, mac_of, mac_uf, mac_nx} = o_ret.flg;
         e = fmt(o_ret);
         exp_q.push_back(e);
         ff_m = ff_m | e.flags;
         retired_m++;
      end
      if (iv && !acc) stall_m++;
      if (acc) begin
         o_new.due  = cyc + MAC_LAT;
         o_new.raw  = raw;
         o_new.flg  = flg;
         o_new.mode = md;
         o_new.tag  = tg;
         pend.push_back(o_new);
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 2'b00, '0, '0, 4'b0, ordy, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_tests++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_tests++; if (out_tag !== '0)     begin n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
      n_tests++; if (out_flags !== '0)   begin n_fail++; $display("FAIL reset_out_flags: got %b want 0", out_flags); end
      n_tests++; if (fflags !== '0)      begin n_fail++; $display("FAIL reset_fflags: got %b want 0", fflags); end
   endtask

   task automatic test_fp32_single();
      do_reset();
      step(1'b1, 2'b10, 4'd3, {$urandom, $urandom, $urandom, 32'h3F800000}, 4'b0, 1'b1, 1'b0);
      for (int k = 1; k <= MAC_LAT + 1; k++) begin
         n_tests++;
         if (out_valid !== (k == MAC_LAT + 1)) begin
            n_fail++; $display("FAIL latency_t+%0d: out_valid got %b want %b", k, out_valid, (k == MAC_LAT + 1));
         end
         if (k <= MAC_LAT) idle(1'b1);
      end
      n_tests++; if (out_data !== {96'b0, 32'h3F800000}) begin n_fail++; $display("FAIL fp32_data: got %h want 3f800000", out_data); end
      n_tests++; if (out_tag !== 4'd3) begin n_fail++; $display("FAIL fp32_tag: got %0d want 3", out_tag); end
      idle(1'b1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp32_popped: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_format();
      do_reset();
      step(1'b1, 2'b00, 4'd5, {$urandom, $urandom, $urandom, 32'hDEAD3C00}, 4'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, 4'd6, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0, 1'b0);
      idle(1'b0);
      n_tests++; if (out_data !== 128'h3C00) begin n_fail++; $display("FAIL fmt_fp16_data: got %h want 3c00", out_data); end
      idle(1'b1);
      n_tests++; if (out_data !== '0)      begin n_fail++; $display("FAIL fmt_rsvd_data: got %h want 0", out_data); end
      n_tests++; if (out_flags !== 4'b1000) begin n_fail++; $display("FAIL fmt_rsvd_flags: got %b want 1000", out_flags); end
      n_tests++; if (fflags[3] !== 1'b1)   begin n_fail++; $display("FAIL fmt_rsvd_sticky_nv: got %b want 1", fflags[3]); end
      n_tests++; if (fflags !== ff_m)      begin n_fail++; $display("FAIL fmt_fflags: got %b want %b", fflags, ff_m); end
   endtask

   task automatic test_credit_stall();
      logic exp_r;
      do_reset();
      for (int i = 0; i < 2 * DEPTH; i++) begin
         exp_r = (i < DEPTH);
         n_tests++; if (in_ready !== exp_r) begin n_fail++; $display("FAIL credit_in_ready_%0d: got %b want %b", i, in_ready, exp_r); end
         step(1'b1, 2'($urandom_range(0, 2)), 4'(i), {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b0, 1'b0);
      end
      for (int k = 0; k < DEPTH; k++) begin
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL credit_drain_valid_%0d: got %b want 1", k, out_valid); end
         n_tests++; if (out_tag !== 4'(k)) begin n_fail++; $display("FAIL credit_drain_tag_%0d: got %0d want %0d", k, out_tag, k); end
         n_tests++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL credit_drain_model_%0d: got empty want entry", k); end
         else if (out_data !== exp_q[0].data || out_flags !== exp_q[0].flags) begin
            n_fail++; $display("FAIL credit_drain_data_%0d: got %h/%b want %h/%b", k, out_data, out_flags, exp_q[0].data, exp_q[0].flags);
         end
         idle(1'b1);
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL credit_empty: out_valid got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL credit_restored: in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_sticky();
      do_reset();
      step(1'b1, 2'b10, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 4'b0100, 1'b1, 1'b0);
      step(1'b1, 2'b10, 4'd1, {$urandom, $urandom, $urandom, $urandom}, 4'b0001, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      n_tests++; if (fflags !== 4'b0101) begin n_fail++; $display("FAIL sticky_accrue: got %b want 0101", fflags); end
      step(1'b1, 2'b01, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 4'b0001, 1'b1, 1'b0);
      idle(1'b1);
      step(1'b0, 2'b00, '0, '0, 4'b0, 1'b1, 1'b1);
      n_tests++; if (fflags !== 4'b0001) begin n_fail++; $display("FAIL sticky_clr_with_set: got %b want 0001", fflags); end
      step(1'b0, 2'b00, '0, '0, 4'b0, 1'b1, 1'b1);
      n_tests++; if (fflags !== 4'b0000) begin n_fail++; $display("FAIL sticky_clr: got %b want 0000", fflags); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'b10, 4'(i + 8), {$urandom, $urandom, $urandom, $urandom}, 4'b1111, 1'b0, 1'b0);
      do_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      for (int k = 0; k < MAC_LAT + 2; k++) begin
         idle(1'b1);
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_%0d: out_valid got %b want 0", k, out_valid); end
         n_tests++; if (fflags !== 4'b0)    begin n_fail++; $display("FAIL midrst_fflags_%0d: got %b want 0", k, fflags); end
      end
   endtask

   task automatic test_back_to_back();
      int got;
      got = 0;
      do_reset();
      for (int i = 0; i < 100 + MAC_LAT + 4; i++) begin
         if (i < 100) begin
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_%0d: got %b want 1", i, in_ready); end
         end
         n_tests++;
         if (out_valid !== (exp_q.size() > 0)) begin
            n_fail++; $display("FAIL b2b_valid_%0d: got %b want %b", i, out_valid, (exp_q.size() > 0));
         end else if (out_valid && (out_data !== exp_q[0].data || out_tag !== exp_q[0].tag || out_flags !== exp_q[0].flags)) begin
            n_fail++; $display("FAIL b2b_entry_%0d: got %h/%h/%b want %h/%h/%b", i, out_data, out_tag, out_flags,
                               exp_q[0].data, exp_q[0].tag, exp_q[0].flags);
         end
         if (out_valid) got++;
         if (i < 100) step(1'b1, 2'($urandom), 4'(i), {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'b1, 1'b0);
         else         idle(1'b1);
      end
      n_tests++; if (got !== 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", got); end
`ifdef MAC_RES_PERF_CNT_EN
      n_tests++; if (perf_retired !== 32'd100) begin n_fail++; $display("FAIL perf_retired: got %0d want 100", perf_retired); end
      n_tests++; if (perf_stall !== 32'd0)     begin n_fail++; $display("FAIL perf_stall: got %0d want 0", perf_stall); end
`endif
   endtask

   task automatic test_random();
      logic exp_r;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         exp_r = ((pend.size() + exp_q.size()) < DEPTH);
         n_tests++; if (in_ready !== exp_r) begin n_fail++; $display("FAIL rnd_in_ready_%0d: got %b want %b", i, in_ready, exp_r); end
         n_tests++;
         if (out_valid !== (exp_q.size() > 0)) begin
            n_fail++; $display("FAIL rnd_valid_%0d: got %b want %b", i, out_valid, (exp_q.size() > 0));
         end else if (out_valid && (out_data !== exp_q[0].data || out_tag !== exp_q[0].tag || out_flags !== exp_q[0].flags)) begin
            n_fail++; $display("FAIL rnd_entry_%0d: got %h/%h/%b want %h/%h/%b", i, out_data, out_tag, out_flags,
                               exp_q[0].data, exp_q[0].tag, exp_q[0].flags);
         end
         n_tests++; if (fflags !== ff_m) begin n_fail++; $display("FAIL rnd_fflags_%0d: got %b want %b", i, fflags, ff_m); end
`ifdef MAC_RES_PERF_CNT_EN
         n_tests++;
         if (perf_retired !== retired_m || perf_stall !== stall_m) begin
            n_fail++; $display("FAIL rnd_perf_%0d: got %0d/%0d want %0d/%0d", i, perf_retired, perf_stall, retired_m, stall_m);
         end
`endif
         step(($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
              4'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_mode    = 2'b00;
      in_tag     = '0;
      out_ready  = 1'b0;
      fflags_clr = 1'b0;
      mac_result = '0;
      {mac_nv, mac_of, mac_uf, mac_nx} = 4'b0;
      test_reset();
      test_fp32_single();
      test_format();
      test_credit_stall();
      test_sticky();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
